// File: rtl/param_ud_counter_seg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : param_ud_counter_seg                                          |
// | Purpose  : Parametrised modulo-N up/down counter with synchronous load,  |
// |            count enable, wrap or saturate mode, terminal-count and       |
// |            overflow flags, and an optional 7-segment hex decode of the   |
// |            low nibble of the count.                                      |
// | Option   : SEG_DECODE_EN - when defined, seg carries the hex decode of   |
// |            out[3:0]; when undefined, seg is tied low and no decoder is   |
// |            built.                                                        |
// | Params   : WIDTH     counter width in bits (2..16)                       |
// |            MODULUS   count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH  |
// |            SAT_MODE  0 = wrap at range ends, 1 = saturate                |
// |            RESET_VAL value taken on reset, < MODULUS                     |
// | Ports    : clk      in   rising-edge clock                               |
// |            reset    in   synchronous active-high reset                   |
// |            en       in   count enable                                    |
// |            x        in   direction, 1 = up, 0 = down                     |
// |            load     in   synchronous parallel load strobe                |
// |            load_val in   WIDTH-bit load value (clamped to MODULUS-1)     |
// |            out      out  registered count                                |
// |            tc       out  terminal count, combinational from out and x    |
// |            ovf      out  registered one-cycle wrap/saturation pulse      |
// |            seg      out  active-high segments {a,b,c,d,e,f,g}            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module param_ud_counter_seg #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int SAT_MODE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf,
  output logic [6:0]       seg
);

  // All range arithmetic is done one bit wider than the counter so that
  // MODULUS == 2**WIDTH is representable and nothing wraps silently.
  localparam logic [WIDTH:0]   C_MOD   = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   C_MAX   = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] C_RST   = WIDTH'(RESET_VAL);
  localparam logic             C_SAT   = (SAT_MODE != 0);

  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   ld_ext;
  logic [WIDTH:0]   cnt_inc;
  logic [WIDTH:0]   cnt_dec;
  logic             at_max;
  logic             at_min;

  assign cnt_ext = {1'b0, out_q};
  assign ld_ext  = {1'b0, load_val};
  assign cnt_inc = cnt_ext + 1'b1;
  assign cnt_dec = cnt_ext - 1'b1;
  assign at_max  = (cnt_ext == C_MAX);
  assign at_min  = (out_q == '0);

  always_comb begin
    out_d = out_q;
    ovf_d = 1'b0;
    if (load) begin
      // Out-of-range load values clamp to the top of the range.
      out_d = (ld_ext < C_MOD) ? load_val : C_MAX[WIDTH-1:0];
    end else if (en) begin
      if (x) begin
        if (at_max) begin
          ovf_d = 1'b1;
          out_d = C_SAT ? out_q : '0;
        end else begin
          out_d = cnt_inc[WIDTH-1:0];
        end
      end else begin
        if (at_min) begin
          ovf_d = 1'b1;
          out_d = C_SAT ? out_q : C_MAX[WIDTH-1:0];
        end else begin
          out_d = cnt_dec[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= C_RST;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign out = out_q;
  assign ovf = ovf_q;
  // Terminal count follows the live direction input, so a cascade can look
  // ahead to the wrap in either direction.
  assign tc  = x ? at_max : at_min;

`ifdef SEG_DECODE_EN
  logic [15:0] out_zx;
  logic [3:0]  nib;
  logic [6:0]  seg_d;

  // Zero-extension covers WIDTH < 4 without a width-dependent slice.
  assign out_zx = 16'(out_q);
  assign nib    = out_zx[3:0];

  always_comb begin
    seg_d = 7'b0000000;
    case (nib)
      4'h0: seg_d = 7'b1111110;
      4'h1: seg_d = 7'b0110000;
      4'h2: seg_d = 7'b1101101;
      4'h3: seg_d = 7'b1111001;
      4'h4: seg_d = 7'b0110011;
      4'h5: seg_d = 7'b1011011;
      4'h6: seg_d = 7'b1011111;
      4'h7: seg_d = 7'b1110000;
      4'h8: seg_d = 7'b1111111;
      4'h9: seg_d = 7'b1111011;
      4'hA: seg_d = 7'b1110111;
      4'hB: seg_d = 7'b0011111;
      4'hC: seg_d = 7'b1001110;
      4'hD: seg_d = 7'b0111101;
      4'hE: seg_d = 7'b1001111;
      4'hF: seg_d = 7'b1000111;
      default: seg_d = 7'b0000000;
    endcase
  end

  assign seg = seg_d;
`else
  assign seg = 7'b0000000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_ud_counter_seg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_param_ud_counter_seg                                       |
// | Purpose  : Directed self-checking bench for param_ud_counter_seg. Three  |
// |            instances: defaults (a), MODULUS=10 wrap (b), MODULUS=10      |
// |            saturate (c). Honours SEG_DECODE_EN for the seg checks.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_param_ud_counter_seg;

  logic       clk = 1'b0;
  logic       reset;

  logic       en_a, x_a, load_a;
  logic [3:0] lv_a, out_a;
  logic       tc_a, ovf_a;
  logic [6:0] seg_a;

  logic       en_b, x_b, load_b;
  logic [3:0] lv_b, out_b;
  logic       tc_b, ovf_b;
  logic [6:0] seg_b;

  logic       en_c, x_c, load_c;
  logic [3:0] lv_c, out_c;
  logic       tc_c, ovf_c;
  logic [6:0] seg_c;

  int checks   = 0;
  int failures = 0;

  logic [6:0] seg_tab [16];

  always #5 clk = ~clk;

  param_ud_counter_seg #(.WIDTH(4), .MODULUS(16), .SAT_MODE(0), .RESET_VAL(0)) u_a (
    .clk(clk), .reset(reset), .en(en_a), .x(x_a), .load(load_a),
    .load_val(lv_a), .out(out_a), .tc(tc_a), .ovf(ovf_a), .seg(seg_a));

  param_ud_counter_seg #(.WIDTH(4), .MODULUS(10), .SAT_MODE(0), .RESET_VAL(0)) u_b (
    .clk(clk), .reset(reset), .en(en_b), .x(x_b), .load(load_b),
    .load_val(lv_b), .out(out_b), .tc(tc_b), .ovf(ovf_b), .seg(seg_b));

  param_ud_counter_seg #(.WIDTH(4), .MODULUS(10), .SAT_MODE(1), .RESET_VAL(0)) u_c (
    .clk(clk), .reset(reset), .en(en_c), .x(x_c), .load(load_c),
    .load_val(lv_c), .out(out_c), .tc(tc_c), .ovf(ovf_c), .seg(seg_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    seg_tab[0]  = 7'b1111110; seg_tab[1]  = 7'b0110000;
    seg_tab[2]  = 7'b1101101; seg_tab[3]  = 7'b1111001;
    seg_tab[4]  = 7'b0110011; seg_tab[5]  = 7'b1011011;
    seg_tab[6]  = 7'b1011111; seg_tab[7]  = 7'b1110000;
    seg_tab[8]  = 7'b1111111; seg_tab[9]  = 7'b1111011;
    seg_tab[10] = 7'b1110111; seg_tab[11] = 7'b0011111;
    seg_tab[12] = 7'b1001110; seg_tab[13] = 7'b0111101;
    seg_tab[14] = 7'b1001111; seg_tab[15] = 7'b1000111;

    reset = 1'b1;
    en_a = 1'b1; x_a = 1'b1; load_a = 1'b0; lv_a = 4'd0;
    en_b = 1'b0; x_b = 1'b0; load_b = 1'b0; lv_b = 4'd0;
    en_c = 1'b0; x_c = 1'b0; load_c = 1'b0; lv_c = 4'd0;

    // 1: reset held three cycles against an active enable
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out", out_a, 0);
      chk("rst_ovf", ovf_a, 0);
    end
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("post_rst_cnt", out_a, i);
    end

    // 2: wrap up on the default instance
    load_a = 1'b1; lv_a = 4'd14;
    tick();
    chk("ld14_out", out_a, 14);
    chk("ld14_tc", tc_a, 0);
    chk("ld14_ovf", ovf_a, 0);
    load_a = 1'b0;
    tick();
    chk("up15_out", out_a, 15);
    chk("up15_tc", tc_a, 1);
    chk("up15_ovf", ovf_a, 0);
    tick();
    chk("wrap0_out", out_a, 0);
    chk("wrap0_ovf", ovf_a, 1);
    chk("wrap0_tc", tc_a, 0);
    tick();
    chk("up1_out", out_a, 1);
    chk("up1_ovf", ovf_a, 0);
    en_a = 1'b0;
    tick();
    chk("hold_out", out_a, 1);
    chk("hold_ovf", ovf_a, 0);

    // 3: wrap down, MODULUS=10; load wins over en on the same edge
    load_b = 1'b1; lv_b = 4'd1; en_b = 1'b1; x_b = 1'b0;
    tick();
    chk("b_ld1", out_b, 1);
    load_b = 1'b0;
    tick();
    chk("b_dn0", out_b, 0);
    chk("b_tc0", tc_b, 1);
    chk("b_ovf0", ovf_b, 0);
    tick();
    chk("b_wrap9", out_b, 9);
    chk("b_wrap_ovf", ovf_b, 1);
    tick();
    chk("b_dn8", out_b, 8);
    chk("b_dn8_ovf", ovf_b, 0);
    en_b = 1'b0; load_b = 1'b1; lv_b = 4'd12;
    tick();
    chk("b_clamp", out_b, 9);
    chk("b_clamp_ovf", ovf_b, 0);
    load_b = 1'b0; x_b = 1'b1;
    tick();
    chk("b_hold", out_b, 9);
    chk("b_tc_up9", tc_b, 1);

    // 4: saturate, MODULUS=10
    load_c = 1'b1; lv_c = 4'd8;
    tick();
    chk("c_ld8", out_c, 8);
    load_c = 1'b0; en_c = 1'b1; x_c = 1'b1;
    tick();
    chk("c_up9", out_c, 9);
    chk("c_up9_ovf", ovf_c, 0);
    tick();
    chk("c_sat1", out_c, 9);
    chk("c_sat1_ovf", ovf_c, 1);
    tick();
    chk("c_sat2", out_c, 9);
    chk("c_sat2_ovf", ovf_c, 1);
    x_c = 1'b0;
    tick();
    chk("c_dn8", out_c, 8);
    chk("c_dn8_ovf", ovf_c, 0);
    en_c = 1'b0; load_c = 1'b1; lv_c = 4'd0;
    tick();
    load_c = 1'b0; en_c = 1'b1;
    tick();
    chk("c_sat_lo", out_c, 0);
    chk("c_sat_lo_ovf", ovf_c, 1);
    en_c = 1'b0;

    // 5: priority reset > load > en
    load_a = 1'b1; lv_a = 4'd2;
    tick();
    chk("prio_ld2", out_a, 2);
    en_a = 1'b1; x_a = 1'b1; lv_a = 4'd5;
    tick();
    chk("prio_ld_over_en", out_a, 5);
    reset = 1'b1;
    tick();
    chk("prio_rst_out", out_a, 0);
    chk("prio_rst_ovf", ovf_a, 0);
    reset = 1'b0; load_a = 1'b0; x_a = 1'b0;
    tick();
    chk("dn_wrap15", out_a, 15);
    chk("dn_wrap_ovf", ovf_a, 1);
    en_a = 1'b0;

    // 6: seg sweep over every nibble value
    load_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      lv_a = 4'(i);
      tick();
      chk("sweep_out", out_a, i);
`ifdef SEG_DECODE_EN
      chk("seg_decode", seg_a, seg_tab[i]);
`else
      chk("seg_tied", seg_a, 0);
`endif
    end
    load_a = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
